// File: rtl/cal_pkg.sv
// Shared field widths and calendar constants for the calendar counter.
package cal_pkg;
    localparam int WD_W    = 3;
    localparam int MDAY_W  = 5;
    localparam int MONTH_W = 4;

    localparam logic [MONTH_W-1:0] MONTHS        = 4'd12;
    localparam logic [WD_W-1:0]    DAYS_PER_WEEK = 3'd7;
    localparam logic [MDAY_W-1:0]  FEB_LEAP      = 5'd29;
    localparam logic [MDAY_W-1:0]  FEB_NORM      = 5'd28;
endpackage

// File: rtl/cal_month_len.sv
// Days-in-month lookup; an out-of-range month yields length 0 so any mday fails validation.
module cal_month_len
    import cal_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic               leap,
    output logic [MDAY_W-1:0]  len
);
    // Month length table with leap-year February
    always_comb begin
        len = 5'd0;
        case (month)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: len = 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    len = 5'd30;
            4'd2: begin
                if (leap) begin
                    len = FEB_LEAP;
                end else begin
                    len = FEB_NORM;
                end
            end
            default: len = 5'd0;
        endcase
    end
endmodule

// File: rtl/calendar_counter.sv
// Day/month/year/weekday counter with validated load, rollover pulses and an enable-gated output bus.
module calendar_counter
    import cal_pkg::*;
#(
    parameter int YEAR_W   = 7,
    parameter int WD_RESET = 1
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                tick,
    input  logic                load,
    input  logic                enable,
    input  logic [WD_W-1:0]     ld_weekday,
    input  logic [MDAY_W-1:0]   ld_mday,
    input  logic [MONTH_W-1:0]  ld_month,
    input  logic [YEAR_W-1:0]   ld_year,
    output logic [WD_W-1:0]     weekday,
    output logic [MDAY_W-1:0]   mday,
    output logic [MONTH_W-1:0]  month,
    output logic [YEAR_W-1:0]   year,
    output logic [WD_W-1:0]     dout_weekday,
    output logic [MDAY_W-1:0]   dout_mday,
    output logic [MONTH_W-1:0]  dout_month,
    output logic [YEAR_W-1:0]   dout_year,
    output logic                new_month,
    output logic                new_year,
    output logic                load_err
);
    localparam logic [WD_W-1:0]   WD_INIT  = WD_W'(WD_RESET);
    localparam logic [YEAR_W-1:0] YEAR_ONE = {{(YEAR_W-1){1'b0}}, 1'b1};

    logic [WD_W-1:0]    weekday_r, weekday_s;
    logic [MDAY_W-1:0]  mday_r, mday_s;
    logic [MONTH_W-1:0] month_r, month_s;
    logic [YEAR_W-1:0]  year_r, year_s;
    logic               new_month_r, new_month_s;
    logic               new_year_r, new_year_s;
    logic               load_err_r, load_err_s;
    logic [MDAY_W-1:0]  cur_len_s, ld_len_s;
    logic               ld_ok_s;

    cal_month_len u_cur_len (
        .month (month_r),
        .leap  (year_r[1:0] == 2'd0),
        .len   (cur_len_s)
    );

    cal_month_len u_ld_len (
        .month (ld_month),
        .leap  (ld_year[1:0] == 2'd0),
        .len   (ld_len_s)
    );

    // An illegal month gives ld_len_s == 0, which also rejects every mday
    assign ld_ok_s = (ld_weekday != 3'd0)
                   && (ld_month >= 4'd1) && (ld_month <= MONTHS)
                   && (ld_mday >= 5'd1) && (ld_mday <= ld_len_s);

    // Next-date selection: load beats tick beats hold
    always_comb begin
        weekday_s   = weekday_r;
        mday_s      = mday_r;
        month_s     = month_r;
        year_s      = year_r;
        new_month_s = 1'b0;
        new_year_s  = 1'b0;
        load_err_s  = 1'b0;
        if (load) begin
            if (ld_ok_s) begin
                weekday_s = ld_weekday;
                mday_s    = ld_mday;
                month_s   = ld_month;
                year_s    = ld_year;
            end else begin
                load_err_s = 1'b1;
            end
        end else if (tick) begin
            if (weekday_r == DAYS_PER_WEEK) begin
                weekday_s = 3'd1;
            end else begin
                weekday_s = weekday_r + 3'd1;
            end
            if (mday_r == cur_len_s) begin
                mday_s      = 5'd1;
                new_month_s = 1'b1;
                if (month_r == MONTHS) begin
                    month_s    = 4'd1;
                    year_s     = year_r + YEAR_ONE;
                    new_year_s = 1'b1;
                end else begin
                    month_s = month_r + 4'd1;
                end
            end else begin
                mday_s = mday_r + 5'd1;
            end
        end else begin
            weekday_s = weekday_r;
        end
    end

    // Date and status registers
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            weekday_r   <= WD_INIT;
            mday_r      <= 5'd1;
            month_r     <= 4'd1;
            year_r      <= '0;
            new_month_r <= 1'b0;
            new_year_r  <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            weekday_r   <= weekday_s;
            mday_r      <= mday_s;
            month_r     <= month_s;
            year_r      <= year_s;
            new_month_r <= new_month_s;
            new_year_r  <= new_year_s;
            load_err_r  <= load_err_s;
        end
    end

    assign weekday   = weekday_r;
    assign mday      = mday_r;
    assign month     = month_r;
    assign year      = year_r;
    assign new_month = new_month_r;
    assign new_year  = new_year_r;
    assign load_err  = load_err_r;

    assign dout_weekday = {WD_W{enable}}    & weekday_r;
    assign dout_mday    = {MDAY_W{enable}}  & mday_r;
    assign dout_month   = {MONTH_W{enable}} & month_r;
    assign dout_year    = {YEAR_W{enable}}  & year_r;
endmodule

// File: tb/tb_calendar_counter.sv
// Directed-vector bench for calendar_counter with hand-computed expected dates.
module tb_calendar_counter;
    logic       clk = 1'b0;
    logic       clear_n, tick, load, enable;
    logic [2:0] ld_weekday;
    logic [4:0] ld_mday;
    logic [3:0] ld_month;
    logic [6:0] ld_year;
    logic [2:0] weekday, dout_weekday;
    logic [4:0] mday, dout_mday;
    logic [3:0] month, dout_month;
    logic [6:0] year, dout_year;
    logic       new_month, new_year, load_err;

    int n_vec = 0;
    int n_err = 0;
    int nm_count;

    calendar_counter #(.YEAR_W(7), .WD_RESET(1)) dut (
        .clk          (clk),
        .clear_n      (clear_n),
        .tick         (tick),
        .load         (load),
        .enable       (enable),
        .ld_weekday   (ld_weekday),
        .ld_mday      (ld_mday),
        .ld_month     (ld_month),
        .ld_year      (ld_year),
        .weekday      (weekday),
        .mday         (mday),
        .month        (month),
        .year         (year),
        .dout_weekday (dout_weekday),
        .dout_mday    (dout_mday),
        .dout_month   (dout_month),
        .dout_year    (dout_year),
        .new_month    (new_month),
        .new_year     (new_year),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare date fields packed as {weekday, mday, month, year}
    task automatic check_date(input string tag, input logic [2:0] wd, input logic [4:0] md,
                              input logic [3:0] mo, input logic [6:0] yr);
        check(tag, {13'd0, weekday, mday, month, year}, {13'd0, wd, md, mo, yr});
    endtask

    task automatic check_flags(input string tag, input logic nm, input logic ny, input logic le);
        check(tag, {29'd0, new_month, new_year, load_err}, {29'd0, nm, ny, le});
    endtask

    task automatic do_load(input logic [2:0] wd, input logic [4:0] md,
                           input logic [3:0] mo, input logic [6:0] yr, input logic tk);
        load = 1'b1; tick = tk;
        ld_weekday = wd; ld_mday = md; ld_month = mo; ld_year = yr;
        step();
        load = 1'b0; tick = 1'b0;
    endtask

    initial begin
        clear_n = 1'b0; tick = 1'b0; load = 1'b0; enable = 1'b1;
        ld_weekday = 3'd0; ld_mday = 5'd0; ld_month = 4'd0; ld_year = 7'd0;
        #12;
        check_date("reset_date", 3'd1, 5'd1, 4'd1, 7'd0);
        check_flags("reset_flags", 1'b0, 1'b0, 1'b0);

        // tick and load ignored while held in reset
        tick = 1'b1; load = 1'b1; ld_weekday = 3'd3; ld_mday = 5'd9; ld_month = 4'd5;
        step();
        check_date("tick_in_reset", 3'd1, 5'd1, 4'd1, 7'd0);
        load = 1'b0;

        clear_n = 1'b1;
        nm_count = 0;
        for (int i = 0; i < 31; i++) begin
            step();
            if (new_month) nm_count++;
        end
        tick = 1'b0;
        step();
        if (new_month) nm_count++;
        check_date("31_ticks", 3'd4, 5'd1, 4'd2, 7'd0);
        check("new_month_count", nm_count, 32'd1);

        // Load wins over same-cycle tick
        do_load(3'd5, 5'd28, 4'd2, 7'd4, 1'b1);
        check_date("load_28feb_y4", 3'd5, 5'd28, 4'd2, 7'd4);
        check_flags("load_ok_flags", 1'b0, 1'b0, 1'b0);
        tick = 1'b1;
        step();
        check_date("leap_29feb", 3'd6, 5'd29, 4'd2, 7'd4);
        check_flags("leap_29feb_flags", 1'b0, 1'b0, 1'b0);
        step();
        check_date("leap_1mar", 3'd7, 5'd1, 4'd3, 7'd4);
        check_flags("leap_1mar_flags", 1'b1, 1'b0, 1'b0);
        tick = 1'b0;

        do_load(3'd7, 5'd28, 4'd2, 7'd5, 1'b0);
        tick = 1'b1;
        step();
        check_date("norm_1mar", 3'd1, 5'd1, 4'd3, 7'd5);
        check_flags("norm_1mar_flags", 1'b1, 1'b0, 1'b0);
        tick = 1'b0;

        do_load(3'd3, 5'd31, 4'd12, 7'd127, 1'b0);
        tick = 1'b1;
        step();
        check_date("year_wrap", 3'd4, 5'd1, 4'd1, 7'd0);
        check_flags("year_wrap_flags", 1'b1, 1'b1, 1'b0);
        tick = 1'b0;
        step();
        check_flags("pulse_one_cycle", 1'b0, 1'b0, 1'b0);

        // Illegal loads with tick high: state held, load_err pulsed
        do_load(3'd2, 5'd31, 4'd4, 7'd9, 1'b1);
        check_date("bad_31apr", 3'd4, 5'd1, 4'd1, 7'd0);
        check_flags("bad_31apr_flags", 1'b0, 1'b0, 1'b1);
        step();
        check_flags("load_err_clear", 1'b0, 1'b0, 1'b0);
        do_load(3'd1, 5'd1, 4'd13, 7'd3, 1'b1);
        check_date("bad_month13", 3'd4, 5'd1, 4'd1, 7'd0);
        check_flags("bad_month13_flags", 1'b0, 1'b0, 1'b1);
        do_load(3'd0, 5'd10, 4'd6, 7'd3, 1'b1);
        check_date("bad_wd0", 3'd4, 5'd1, 4'd1, 7'd0);
        check_flags("bad_wd0_flags", 1'b0, 1'b0, 1'b1);
        do_load(3'd2, 5'd29, 4'd2, 7'd5, 1'b0);
        check_date("bad_29feb_y5", 3'd4, 5'd1, 4'd1, 7'd0);
        check_flags("bad_29feb_y5_flags", 1'b0, 1'b0, 1'b1);

        // enable gating of the dout bus
        enable = 1'b0; tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("dout_gated", {13'd0, dout_weekday, dout_mday, dout_month, dout_year}, 32'd0);
        end
        tick = 1'b0;
        #1;
        enable = 1'b1;
        #1;
        check("dout_enabled", {13'd0, dout_weekday, dout_mday, dout_month, dout_year},
              {13'd0, 3'd7, 5'd4, 4'd1, 7'd0});

        // Asynchronous reset between edges while a pulse is high
        do_load(3'd1, 5'd31, 4'd1, 7'd20, 1'b0);
        tick = 1'b1;
        step();
        check_flags("pre_reset_pulse", 1'b1, 1'b0, 1'b0);
        #2;
        clear_n = 1'b0;
        #1;
        check_date("async_reset_date", 3'd1, 5'd1, 4'd1, 7'd0);
        check_flags("async_reset_flags", 1'b0, 1'b0, 1'b0);
        clear_n = 1'b1;
        step();
        check_date("first_edge_after_reset", 3'd2, 5'd2, 4'd1, 7'd0);
        tick = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
